// File: rtl/instruction_fetch.sv
// instruction_fetch: front-end fetch stage in front of the instruction port of
// the memory controller. It holds the fetch PC, issues one word address per
// cycle to a synchronous 1-cycle memory, captures the returned word into a
// 2-entry queue and hands the queue head to decode over a valid/ready handshake.
// A redirect flushes the in-flight fetch and every buffered word.
//
// Optional feature macro: FETCH_FAULT_EN. When it is defined, each captured
// word carries a fault bit that is set when its PC lies outside the bootloader
// ROM and instruction RAM regions. When it is undefined, o_fault is tied to 0.
//
// Ports:
//   i_clk            clock, rising edge
//   i_rst            synchronous active-high reset
//   o_inst_addr      fetch address (the fetch PC register)
//   i_inst_data      memory word for the address presented in the previous cycle
//   o_valid          queue head holds an instruction
//   o_inst           instruction word at the queue head
//   o_pc             PC of o_inst
//   i_ready          decode takes the head when o_valid && i_ready
//   i_redirect_valid redirect request (branch/jump/trap)
//   i_redirect_pc    redirect target; the low two bits are dropped
//   o_fault          head instruction came from an unmapped region
module instruction_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h1000_0000,
   parameter logic [3:0]  BROM_BASE = 4'h1,
   parameter logic [3:0]  IMEM_BASE = 4'h2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   output logic [31:0] o_inst_addr,
   input  logic [31:0] i_inst_data,
   output logic        o_valid,
   output logic [31:0] o_inst,
   output logic [31:0] o_pc,
   input  logic        i_ready,
   input  logic        i_redirect_valid,
   input  logic [31:0] i_redirect_pc,
   output logic        o_fault
);

   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = 2;

   typedef struct packed {
      logic [XLEN-1:0] inst;
      logic [XLEN-1:0] pc;
`ifdef FETCH_FAULT_EN
      logic            fault;
`endif
   } entry_t;

   logic [XLEN-1:0]  fetch_pc;
   logic             inflight;
   logic [XLEN-1:0]  inflight_pc;
   logic [CNT_W-1:0] count;
   entry_t           q_head;
   entry_t           q_tail;

   logic             pop_c;
   logic [2:0]       occ_c;
   logic             issue_c;
   logic [CNT_W-1:0] fill_c;
   entry_t           new_entry_c;

   // Handshake, occupancy and the entry built from the returning word
   always_comb begin
      pop_c            = (count != '0) && i_ready;
      occ_c            = 3'(count) + 3'(inflight) - 3'(pop_c);
      issue_c          = !i_redirect_valid && (occ_c < 3'd2);
      fill_c           = count - CNT_W'(pop_c);
      new_entry_c      = '0;
      new_entry_c.inst = i_inst_data;
      new_entry_c.pc   = inflight_pc;
`ifdef FETCH_FAULT_EN
      new_entry_c.fault = (inflight_pc[31:28] != BROM_BASE) &&
                          (inflight_pc[31:28] != IMEM_BASE);
`endif
   end

   // PC, in-flight tracking and queue state
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         fetch_pc    <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
         count       <= '0;
         q_head      <= '0;
         q_tail      <= '0;
      end else if (i_redirect_valid) begin
         // Any word in flight belongs to the old path and is dropped
         fetch_pc <= i_redirect_pc & ~32'h3;
         inflight <= 1'b0;
         count    <= '0;
      end else begin
         inflight <= issue_c;
         if (issue_c) begin
            inflight_pc <= fetch_pc;
            fetch_pc    <= fetch_pc + 32'd4;
         end
         if (pop_c) begin
            q_head <= q_tail;
         end
         // Capture lands in the first free slot after this cycle's pop
         if (inflight) begin
            if (fill_c == '0) begin
               q_head <= new_entry_c;
            end else begin
               q_tail <= new_entry_c;
            end
            count <= fill_c + CNT_W'(1);
         end else begin
            count <= fill_c;
         end
      end
   end

   assign o_inst_addr = fetch_pc;
   assign o_valid     = (count != '0);
   assign o_inst      = q_head.inst;
   assign o_pc        = q_head.pc;
`ifdef FETCH_FAULT_EN
   assign o_fault     = q_head.fault;
`else
   assign o_fault     = 1'b0;
`endif

   // The issue rule reserves a slot for every in-flight word
   a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
      !(inflight && !i_redirect_valid && (fill_c == CNT_W'(2))));

   a_regions_distinct: assert property (@(posedge i_clk) BROM_BASE != IMEM_BASE);

endmodule
